// File: rtl/uart_telemetry_tx.sv
// Telemetry UART transmitter: snapshots x/y/data/en on start and sends a 6-byte frame
// {HEADER, x, y, data, status, checksum}, 8N1 or 8E1 when UART_TX_PARITY_EN is defined.
module uart_telemetry_tx #(
  parameter int         CLKS_PER_BIT = 10417,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] data,
  input  logic       en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    x_q, x_d, y_q, y_d, data_q, data_d, chk_q, chk_d;
  logic          en_q, en_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic          bit_end;
  logic [7:0]    next_byte;

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    case (byte_q)
      3'd0:    next_byte = x_q;
      3'd1:    next_byte = y_q;
      3'd2:    next_byte = data_q;
      3'd3:    next_byte = {en_q, 7'b0};
      default: next_byte = chk_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cur_d   = cur_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    en_d    = en_q;
    chk_d   = chk_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == LAST);
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          x_d     = x;
          y_d     = y;
          data_d  = data;
          en_d    = en;
          chk_d   = x ^ y ^ data ^ {en, 7'b0};
          byte_d  = 3'd0;
          cur_d   = HEADER;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          tx_d    = cur_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^cur_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (byte_q == 3'd5) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            cur_d   = next_byte;
            tx_d    = 1'b0;
            state_d = START;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      cur_q   <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      chk_q   <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cur_q   <= cur_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      en_q    <= en_d;
      chk_q   <= chk_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
